srl_delay_bank: RTL
===================

Name: srl_delay_bank

Overview:
- Multi-tap, parametrised delay line; successor to the single-tap shift register.
- One shift chain of DEPTH words, written by a shift enable, with CHANNELS independent read taps sampled together.
- Adds fill-level tracking, per-tap "primed" flags, synchronous flush and a read-valid strobe.
- Sits ahead of the correlator lanes, where several lags of the same antenna stream are needed in the same cycle.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 16, number of chain stages; any integer >= 2, not required to be a power of two.
- CHANNELS, 4, number of independent read taps.
- Derived localparam ABITS = $clog2(DEPTH), tap address width.
- Derived localparam CBITS = $clog2(DEPTH+1), fill-count width.

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- flush_i  input  1  synchronous flush; marks the chain empty.
- wren_i  input  1  shift enable; pushes data_i into stage 0.
- data_i  input  WIDTH  word to push.
- rden_i  input  1  sample all taps this cycle.
- addr_i  input  CHANNELS*ABITS  tap addresses; channel c uses bits [c*ABITS +: ABITS].
- valid_o  output  1  data_o/primed_o updated this cycle from a read.
- data_o  output  CHANNELS*WIDTH  tap words; channel c uses bits [c*WIDTH +: WIDTH].
- primed_o  output  CHANNELS  tap c held a written word when sampled.
- count_o  output  CBITS  number of valid stages, saturating at DEPTH.

Behaviour:
- Reset (reset_n low, asynchronous):
  - valid_o=0, data_o=0, primed_o=0, count_o=0.
  - Chain storage is not reset, so SRL/LUTRAM inference is preserved; primed_o covers undefined contents.
- Shift: on a clock edge with wren_i=1, stage k+1 <= stage k for all k, and stage 0 <= data_i. With wren_i=0 the chain holds.
- Count:
  - With wren_i=1 and flush_i=0, count increments, saturating at DEPTH.
  - With flush_i=1, count <= (wren_i ? 1 : 0).
  - Flush never touches storage; the shift still happens in a flush cycle.
- Read:
  - rden_i=1 at edge t samples pre-edge storage and pre-edge count.
  - Results are registered; data_o and primed_o are valid after edge t, so latency is 1 cycle.
  - valid_o=1 for exactly the cycle following each rden_i=1 cycle.
  - With rden_i=0, valid_o=0 and data_o/primed_o hold their last values.
- Simultaneous write and read: the read returns pre-shift contents. Tap 0 returns the word written at the previous wren_i edge, not the current data_i.
- primed_o[c] = (addr_c < count), evaluated at the sampling edge.
- Address out of range (addr_c >= DEPTH, non-power-of-two DEPTH only): data_o lane c = 0 and primed_o[c] = 0. No wrap-around.
- Reset mid-operation: outputs clear immediately. After release, count restarts at 0, so all taps read as unprimed until refilled.
- Taps may hold equal addresses; each lane independently returns the same word.
- No combinational path from any input to any output.

Decomposition:
- Shared package srl_pkg holds:
  - The ABITS/CBITS derivation functions.
  - A tap-slice helper function used by the correlator front end.
- Natural sub-module: srl_tap_mux, a registered DEPTH:1 read mux with out-of-range zeroing, instantiated CHANNELS times.
- Chain storage and the fill counter stay in the top module.

Test Plan:
- Reset with X-filled chain, then rden_i=1 with all addr=0 -> valid_o=1 next cycle, primed_o=0000, count_o=0.
- Push 0x01..0x05 on consecutive cycles, then read addr={0,1,4,7} -> data_o={05,04,01,xx}, primed_o=0111 (lane3 unprimed), count_o=5.
- Push 20 words 0x10..0x23 -> count_o saturates at 16; read addr=15 returns 0x14, primed=1.
- Same-cycle wren_i=1 (data 0xAA) and rden_i=1 at addr 0 after last push 0x55 -> data_o lane0=0x55; next read returns 0xAA.
- flush_i with wren_i=1 (data 0x77) on a full chain -> count_o=1. Next read at addr {0,1}: lane0=0x77 primed, lane1 primed_o=0 even though storage holds an old word.
- DEPTH=12 build, addr=13 -> data_o lane=0, primed=0. Assert reset_n low mid-burst -> all outputs 0 asynchronously, count restarts from 0.

Source files
------------

// File: rtl/srl_pkg.sv
// Shared sizing and slicing helpers for the multi-tap delay bank and its users.
// Latency: none, compile-time and combinational helpers only.
// Backpressure: not applicable.
package srl_pkg;

    // Width of a tap address that can name any of `depth` stages.
    function automatic int calc_abits(input int depth);
        return $clog2(depth);
    endfunction

    // Width of a fill counter that must represent 0..depth inclusive.
    function automatic int calc_cbits(input int depth);
        return $clog2(depth + 1);
    endfunction

    // LSB of lane `lane` in a flat bus of lanes that are `lane_bits` wide.
    function automatic int tap_lsb(input int lane, input int lane_bits);
        return lane * lane_bits;
    endfunction

endpackage

// File: rtl/srl_tap_mux.sv
// One read tap: picks a chain stage by address and registers it with its primed flag.
// Latency: 1 cycle from i_rden to o_data/o_primed; outputs hold when i_rden is low.
// Backpressure: none, a sample is taken on every i_rden cycle.
module srl_tap_mux
    import srl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int ABITS = calc_abits(DEPTH),
    localparam int CBITS = calc_cbits(DEPTH)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   i_rden,
    input  logic [ABITS-1:0]       i_addr,
    input  logic [DEPTH*WIDTH-1:0] i_chain,
    input  logic [CBITS-1:0]       i_count,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_primed
);

    logic [WIDTH-1:0] w_word;
    logic             w_primed;
    logic [WIDTH-1:0] r_data;
    logic             r_primed;

    // Stage select; addresses past the last stage fall through to zero instead of wrapping.
    always_comb begin
        w_word = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (i_addr == ABITS'(k)) begin
                w_word = i_chain[k*WIDTH +: WIDTH];
            end
        end
    end

    // Count never exceeds DEPTH, so an out-of-range address is also unprimed here.
    assign w_primed = (32'(i_addr) < 32'(i_count));

    // Capture the selected word on a read, otherwise hold the last sample.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data   <= '0;
            r_primed <= 1'b0;
        end else if (i_rden) begin
            r_data   <= w_word;
            r_primed <= w_primed;
        end
    end

    assign o_data   = r_data;
    assign o_primed = r_primed;

endmodule

// File: rtl/srl_delay_bank.sv
// Shift chain of DEPTH words with CHANNELS registered read taps, fill count and primed flags.
// Latency: 1 cycle from rden_i to valid_o/data_o/primed_o; reads see pre-shift contents.
// Backpressure: none, writes and reads are accepted every cycle.
module srl_delay_bank
    import srl_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 4,
    localparam int ABITS   = calc_abits(DEPTH),
    localparam int CBITS   = calc_cbits(DEPTH)
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      flush_i,
    input  logic                      wren_i,
    input  logic [WIDTH-1:0]          data_i,
    input  logic                      rden_i,
    input  logic [CHANNELS*ABITS-1:0] addr_i,
    output logic                      valid_o,
    output logic [CHANNELS*WIDTH-1:0] data_o,
    output logic [CHANNELS-1:0]       primed_o,
    output logic [CBITS-1:0]          count_o
);

    logic [WIDTH-1:0]       r_chain [DEPTH];
    logic [DEPTH*WIDTH-1:0] w_chain_flat;
    logic [CBITS-1:0]       r_count;
    logic                   r_valid;

    // Storage has no reset so the chain can map onto SRL/LUTRAM primitives.
    always_ff @(posedge clock) begin
        if (wren_i) begin
            r_chain[0] <= data_i;
            for (int k = 1; k < DEPTH; k++) begin
                r_chain[k] <= r_chain[k-1];
            end
        end
    end

    // Fill level: flush restarts it (counting a same-cycle write), otherwise saturate at DEPTH.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= wren_i ? CBITS'(1) : '0;
        end else if (wren_i && (r_count != CBITS'(DEPTH))) begin
            r_count <= r_count + CBITS'(1);
        end
    end

    // Read strobe follows rden_i by one cycle, aligned with the tap registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
        end else begin
            r_valid <= rden_i;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_flat
        assign w_chain_flat[k*WIDTH +: WIDTH] = r_chain[k];
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_tap
        srl_tap_mux #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
        ) u_tap (
            .clock    (clock),
            .reset_n  (reset_n),
            .i_rden   (rden_i),
            .i_addr   (addr_i[tap_lsb(c, ABITS) +: ABITS]),
            .i_chain  (w_chain_flat),
            .i_count  (r_count),
            .o_data   (data_o[tap_lsb(c, WIDTH) +: WIDTH]),
            .o_primed (primed_o[c])
        );
    end

    assign valid_o = r_valid;
    assign count_o = r_count;

endmodule
